// File: rtl/ghash_core_if.sv
// Block-input handshake and hash-result bus between the counter-mode stage,
// ghash_core and the tag stage.
interface ghash_core_if;
   logic [127:0] h_in;
   logic [127:0] block_in;
   logic         start_in;
   logic         last_in;
   logic         valid_in;
   logic         ready_out;
   logic [127:0] ghash_out;
   logic         ghash_valid;
   logic         ghash_last;

   modport master (
      output h_in, block_in, start_in, last_in, valid_in,
      input  ready_out, ghash_out, ghash_valid, ghash_last
   );

   modport slave (
      input  h_in, block_in, start_in, last_in, valid_in,
      output ready_out, ghash_out, ghash_valid, ghash_last
   );
endinterface

// File: rtl/ghash_core.sv
// Iterative GHASH accumulator: Y = (Y xor X) * H in GF(2^128), BITS_PER_CYCLE
// multiplier bits per clock. Optional macro GHASH_ZEROIZE_EN clears H after a final block.
module ghash_core #(
   parameter int BITS_PER_CYCLE = 1
) (
   input  logic       clk,
   input  logic       rst,
   ghash_core_if.slave bus
);

   localparam int BLOCK_WIDTH = 128;
   localparam int N           = BLOCK_WIDTH / BITS_PER_CYCLE;
   localparam int CNT_W       = $clog2(N);
   localparam logic [BLOCK_WIDTH-1:0] R = {8'he1, 120'd0};

   typedef enum logic {IDLE, MUL} state_t;

   state_t                 state, state_nxt;
   logic [BLOCK_WIDTH-1:0] h_reg, v_reg, z_reg, x_reg, y_reg;
   logic [BLOCK_WIDTH-1:0] v_step, z_step;
   logic [CNT_W-1:0]       cnt;
   logic                   last_r, valid_r, vlast_r;
   logic                   accept, done;

   // NOTE: every signal written in an always_comb gets a default first, so no
   // path can leave it unassigned and infer a latch.
   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      done      = 1'b0;
      case (state)
         IDLE: begin
            if (bus.valid_in) begin
               accept    = 1'b1;
               state_nxt = MUL;
            end
         end
         MUL: begin
            if (cnt == CNT_W'(N - 1)) begin
               done      = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Unrolled Algorithm 1 steps; X is consumed MSB first, V shifts toward bit 0.
   always_comb begin
      z_step = z_reg;
      v_step = v_reg;
      for (int i = 0; i < BITS_PER_CYCLE; i++) begin
         if (x_reg[BLOCK_WIDTH-1-i]) z_step = z_step ^ v_step;
         v_step = v_step[0] ? ((v_step >> 1) ^ R) : (v_step >> 1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         h_reg   <= '0;
         v_reg   <= '0;
         z_reg   <= '0;
         x_reg   <= '0;
         y_reg   <= '0;
         cnt     <= '0;
         last_r  <= 1'b0;
         valid_r <= 1'b0;
         vlast_r <= 1'b0;
      end else begin
         valid_r <= 1'b0;
         vlast_r <= 1'b0;
         if (accept) begin
            x_reg  <= (bus.start_in ? '0 : y_reg) ^ bus.block_in;
            z_reg  <= '0;
            cnt    <= '0;
            last_r <= bus.last_in;
            if (bus.start_in) begin
               h_reg <= bus.h_in;
               v_reg <= bus.h_in;
            end else begin
               v_reg <= h_reg;
            end
         end else if (state == MUL) begin
            z_reg <= z_step;
            v_reg <= v_step;
            x_reg <= x_reg << BITS_PER_CYCLE;
            cnt   <= cnt + CNT_W'(1);
            if (done) begin
               y_reg   <= z_step;
               valid_r <= 1'b1;
               vlast_r <= last_r;
`ifdef GHASH_ZEROIZE_EN
               if (last_r) begin
                  h_reg <= '0;
                  v_reg <= '0;
               end
`endif
            end
         end
      end
   end

   assign bus.ready_out   = (state == IDLE);
   assign bus.ghash_out   = y_reg;
   assign bus.ghash_valid = valid_r;
   assign bus.ghash_last  = vlast_r;

endmodule

// File: doc/ghash_core.md
# ghash_core

Iterative GHASH accumulator for the AES-GCM datapath, sitting directly downstream of the counter-mode stage. It consumes 128-bit ciphertext/AAD/length blocks and updates Y = (Y xor X) • H in GF(2^128) using the SP 800-38D Algorithm 1 shift-and-add multiplier. It processes BITS_PER_CYCLE multiplier bits per clock. The final Y is the pre-tag value that the tag stage XORs with E(K, J0).

## Interface
- BITS_PER_CYCLE, 1, multiplier bits per clock; legal 1, 2, 4, 8, 16; N = 128/BITS_PER_CYCLE multiply cycles per block
- BLOCK_WIDTH, 128, block/hash-subkey width; fixed at 128
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- h_in  input  128  hash subkey H = E(K, 0^128); sampled only when a block with start_in=1 is accepted
- block_in  input  128  data block X_i, MSB = bit 0 of the GCM bit ordering
- start_in  input  1  block is the first of a message; the accumulator is treated as zero
- last_in  input  1  block is the final (length) block of a message
- valid_in  input  1  block_in/start_in/last_in are valid
- ready_out  output  1  block can be accepted this cycle; high iff state == IDLE
- ghash_out  output  128  accumulator Y, driven directly from its register
- ghash_valid  output  1  one-cycle pulse when Y has been updated for the block just processed
- ghash_last  output  1  qualifies ghash_valid: the completed block had last_in=1

## Operation
- States: IDLE, MUL.
- IDLE: ready_out=1. On valid_in & ready_out, the block is accepted:
  - X_reg <= (start_in ? 0 : Y) xor block_in; Z <= 0; cnt <= 0; last_r <= last_in.
  - If start_in, h_reg <= h_in and V <= h_in; otherwise V <= h_reg.
  - State moves to MUL.
- MUL: each cycle performs BITS_PER_CYCLE unrolled steps. For each bit b of X_reg, taken MSB first:
  - If b = 1, Z ^= V.
  - V = V[0] ? (V >> 1) xor R : V >> 1, where R = 0xE1 followed by 120 zero bits.
  - X_reg shifts left by BITS_PER_CYCLE; cnt increments.
- When cnt == N-1 is processed, at the same edge:
  - Y <= Z_next (the final product).
  - ghash_valid <= 1 and ghash_last <= last_r.
  - State moves to IDLE.
- valid_in while in MUL is ignored; the block is not captured, and the upstream stage holds it until ready_out.
- start_in and last_in both high: a single-block message; this is legal.
- All arithmetic is carry-less XOR with no widening; V and Z are always 128 bits.

## Timing
- Reset values: ready_out=1 (state IDLE), ghash_out=0, ghash_valid=0, ghash_last=0; h_reg, V, Z, X_reg and cnt are all 0.
- Latency: block accepted at edge T. The result and ghash_valid appear at edge T+N, and ghash_valid is high for exactly one cycle.
- ready_out returns high at edge T+N. The next accept is at edge T+N+1 at the earliest, giving a throughput of one block per N+1 cycles.
- ghash_out changes only at completion edges or on reset, and holds otherwise.
- Reset asserted mid-MUL: the block is abandoned, all registers return to their reset values immediately, and no ghash_valid pulse is produced.

## Configuration
- GHASH_ZEROIZE_EN defined:
  - At the completion edge of a block with last_r=1, h_reg and V are cleared to 0, in the same edge as the result is registered.
  - Y is kept so that the tag stage can read it.
  - A following block without start_in then multiplies by H=0.
- GHASH_ZEROIZE_EN undefined: h_reg is retained until the next accepted start_in block.

## Test plan
- Identity key: H = 0x8000…0, single block 0x0123456789abcdeffedcba9876543210 with start_in=last_in=1 -> ghash_out equals the input block; ghash_valid and ghash_last pulse at T+N.
- NIST GCM test case 2: H = 66e94bd4ef8a2c3b884cfa59ca342b2e, blocks 0388dace60b6a392f328c2b971b2fe78 (start) then 00000000000000000000000000000080 (last) -> final ghash_out = f38cbb1ad69223dcc3457ae5b6b0f885. Run this for BITS_PER_CYCLE = 1, 4 and 16.
- Back-to-back: valid_in held high across two blocks -> the second block is accepted exactly at T+N+1; inputs presented during MUL are ignored.
- Restart: after a completed message, a new block with start_in=1 and H=0 -> ghash_out = 0, and the previous Y does not leak into the result.
- Reset mid-operation: assert rst at T+3 -> all outputs go to reset values with no ghash_valid pulse; the next accepted block produces a correct result.
- Zeroize: with GHASH_ZEROIZE_EN defined, run the test case 2 sequence, then send one non-start block 0xffff…f -> ghash_out = 0. With the macro undefined, the same sequence gives a result that is not zero.
